// File: rtl/sum_frame_pkg.sv
// rtl/sum_frame_pkg.sv - shared state encoding, byte-count helper and default sync byte for sum_frame_tx
package sum_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/operand_latch_n.sv
// rtl/operand_latch_n.sv - two operand registers with active-low save strobes and a registered adder
module operand_latch_n #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    output logic [DATA_W:0]   sum_next,
    output logic [DATA_W:0]   sum_q
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   sum_d;

    // sum_next already reflects last cycle's captures; the frame snapshot uses it
    always_comb begin
        a_d      = save_a_n ? a_q : data_input;
        b_d      = save_b_n ? b_q : data_input;
        sum_next = {1'b0, a_q} + {1'b0, b_q};
        sum_d    = sum_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/sum_frame_tx.sv
// rtl/sum_frame_tx.sv - operand capture and framed sum transmit to uart_tx; SUMFRAME_CHECKSUM_EN adds an XOR trailer
module sum_frame_tx
    import sum_frame_pkg::*;
#(
    parameter int         DATA_W    = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         AUTO_SEND = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              send_req,
    input  logic              uart_tx_busy,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    output logic [DATA_W:0]   sum_out,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam int SUM_W  = DATA_W + 1;
    localparam int NBYTES = nbytes(SUM_W);
    localparam int PAD_W  = NBYTES * 8;
`ifdef SUMFRAME_CHECKSUM_EN
    localparam int TOTAL  = NBYTES + 2;
`else
    localparam int TOTAL  = NBYTES + 1;
`endif
    localparam logic [2:0] LAST_IDX = 3'(TOTAL - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic [SUM_W-1:0] snap_q, snap_d;
    logic [SUM_W-1:0] sum_next;
    logic [PAD_W-1:0] snap_pad;
    logic [7:0]       frame_bytes [8];
    logic [2:0]       idx_nxt;

    operand_latch_n #(.DATA_W(DATA_W)) u_operands (
        .clk        (clk),
        .reset      (reset),
        .save_a_n   (save_a_n),
        .save_b_n   (save_b_n),
        .data_input (data_input),
        .sum_next   (sum_next),
        .sum_q      (sum_out)
    );

`ifdef SUMFRAME_CHECKSUM_EN
    logic [7:0] chk_byte;
`endif

    // Frame image built from the snapshot: sync, sum bytes LSB-first, optional trailer
    always_comb begin
        snap_pad = '0;
        snap_pad[SUM_W-1:0] = snap_q;
        for (int k = 0; k < 8; k++) frame_bytes[k] = 8'h00;
        frame_bytes[0] = SYNC_BYTE;
        for (int k = 0; k < NBYTES; k++) frame_bytes[3'(k + 1)] = snap_pad[k*8 +: 8];
`ifdef SUMFRAME_CHECKSUM_EN
        chk_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) chk_byte = chk_byte ^ snap_pad[k*8 +: 8];
        frame_bytes[3'(NBYTES + 1)] = chk_byte;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        snap_d  = snap_q;
        en_d    = 1'b0;
        idx_nxt = idx_q + 3'd1;
        case (state_q)
            IDLE: begin
                if (send_req || ((AUTO_SEND != 0) && !save_b_n)) state_d = LOAD;
            end
            LOAD: begin
                snap_d  = sum_next;
                idx_d   = 3'd0;
                data_d  = SYNC_BYTE;
                state_d = SEND;
            end
            SEND: begin
                if (!uart_tx_busy) begin
                    en_d    = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (uart_tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        data_d  = frame_bytes[idx_nxt];
                        state_d = SEND;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            en_q    <= en_d;
            snap_q  <= snap_d;
        end
    end

    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;
    assign frame_busy   = (state_q != IDLE);
    assign frame_done   = (state_q == DONE);

endmodule

// File: tb/tb_sum_frame_tx.sv
// tb/tb_sum_frame_tx.sv - directed and randomized frame checks with a uart_tx busy responder
module tb_sum_frame_tx;

    logic        clk = 1'b0;
    logic        reset;

    logic        sa0_n, sb0_n, req0, busy0, en0, fb0, fd0;
    logic [11:0] din0;
    logic [7:0]  txd0;
    logic [12:0] sum0;

    logic        sa1_n, sb1_n, req1, busy1, en1, fb1, fd1;
    logic [3:0]  din1;
    logic [7:0]  txd1;
    logic [4:0]  sum1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] got0[$];
    logic [7:0] got1[$];
    logic [7:0] exp_q[$];
    int cyc0 = 0, cnt0 = 0, fall0 = 0, dcyc0 = 0;
    int cyc1 = 0, cnt1 = 0, fall1 = 0, dcyc1 = 0;
    logic [7:0] hold0, hold1;

    sum_frame_tx #(.DATA_W(12)) dut0 (
        .clk(clk), .reset(reset), .save_a_n(sa0_n), .save_b_n(sb0_n),
        .data_input(din0), .send_req(req0), .uart_tx_busy(busy0),
        .uart_tx_en(en0), .uart_tx_data(txd0), .sum_out(sum0),
        .frame_busy(fb0), .frame_done(fd0)
    );

    sum_frame_tx #(.DATA_W(4), .AUTO_SEND(1)) dut1 (
        .clk(clk), .reset(reset), .save_a_n(sa1_n), .save_b_n(sb1_n),
        .data_input(din1), .send_req(req1), .uart_tx_busy(busy1),
        .uart_tx_en(en1), .uart_tx_data(txd1), .sum_out(sum1),
        .frame_busy(fb1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: busy for 10 cycles per accepted strobe
    always @(negedge clk) begin
        cyc0++;
        if (fd0 === 1'b1) dcyc0 = cyc0;
        if (reset) begin
            busy0 = 1'b0; cnt0 = 0;
        end else if (busy0) begin
            chk("no_strobe_while_busy0", 64'(en0), 64'd0);
            chk("data_stable0", 64'(txd0), 64'(hold0));
            cnt0--;
            if (cnt0 == 0) begin busy0 = 1'b0; fall0 = cyc0; end
        end else if (en0 === 1'b1) begin
            busy0 = 1'b1; cnt0 = 10; hold0 = txd0; got0.push_back(txd0);
        end
    end

    always @(negedge clk) begin
        cyc1++;
        if (fd1 === 1'b1) dcyc1 = cyc1;
        if (reset) begin
            busy1 = 1'b0; cnt1 = 0;
        end else if (busy1) begin
            chk("no_strobe_while_busy1", 64'(en1), 64'd0);
            chk("data_stable1", 64'(txd1), 64'(hold1));
            cnt1--;
            if (cnt1 == 0) begin busy1 = 1'b0; fall1 = cyc1; end
        end else if (en1 === 1'b1) begin
            busy1 = 1'b1; cnt1 = 10; hold1 = txd1; got1.push_back(txd1);
        end
    end

    // Reference frame: sync byte, sum bytes LSB-first, optional XOR of sum bytes
    task automatic build_frame(input logic [63:0] sum, input int sum_w);
        logic [7:0] x;
        logic [7:0] b;
        int nb;
        nb = (sum_w + 7) / 8;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < nb; k++) begin
            b = 8'((sum >> (8 * k)) & 64'hFF);
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef SUMFRAME_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic wait_done(input int d, input string tag);
        int n;
        n = 0;
        while (((d == 0) ? fd0 : fd1) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    task automatic check_frame(input int d, input string tag, input logic [63:0] sum);
        logic [7:0] g[$];
        build_frame(sum, (d == 0) ? 13 : 5);
        wait_done(d, tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'((d == 0) ? fd0 : fd1), 64'd0);
        chk({tag, "_done_lag"}, 64'((d == 0) ? dcyc0 - fall0 : dcyc1 - fall1), 64'd1);
        g = (d == 0) ? got0 : got1;
        chk({tag, "_len"}, 64'(g.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < g.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(g[i]), 64'(exp_q[i]));
        if (d == 0) got0.delete(); else got1.delete();
    endtask

    task automatic save0(input logic a_n, input logic b_n, input logic [11:0] v, input logic r);
        @(negedge clk);
        sa0_n = a_n; sb0_n = b_n; din0 = v; req0 = r;
        @(negedge clk);
        sa0_n = 1'b1; sb0_n = 1'b1; req0 = 1'b0;
    endtask

    task automatic save1(input logic a_n, input logic b_n, input logic [3:0] v);
        @(negedge clk);
        sa1_n = a_n; sb1_n = b_n; din1 = v;
        @(negedge clk);
        sa1_n = 1'b1; sb1_n = 1'b1;
    endtask

    initial begin
        logic [11:0] ra, rb;
        int n;
        reset = 1'b1;
        sa0_n = 1'b1; sb0_n = 1'b1; din0 = '0; req0 = 1'b0;
        sa1_n = 1'b1; sb1_n = 1'b1; din1 = '0; req1 = 1'b0;
        busy0 = 1'b0; busy1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", 64'(en0), 64'd0);
        chk("rst_data", 64'(txd0), 64'd0);
        chk("rst_sum", 64'(sum0), 64'd0);
        chk("rst_busy", 64'(fb0), 64'd0);
        chk("rst_done", 64'(fd0), 64'd0);
        chk("rst_sum1", 64'(sum1), 64'd0);
        reset = 1'b0;

        // 12-bit carry into the top sum byte
        save0(1'b0, 1'b1, 12'hFFF, 1'b0);
        save0(1'b1, 1'b0, 12'h001, 1'b0);
        @(negedge clk);
        chk("sum_fff_1", 64'(sum0), 64'h1000);
        save0(1'b1, 1'b1, 12'h000, 1'b1);
        chk("frame_busy_on_req", 64'(fb0), 64'd1);
        check_frame(0, "carry", 64'h1000);

        // mid-frame capture and ignored request
        save0(1'b1, 1'b1, 12'h000, 1'b1);
        n = 0;
        while (got0.size() < 1 && n < 500) begin @(negedge clk); n++; end
        save0(1'b0, 1'b1, 12'h003, 1'b0);
        repeat (5) @(negedge clk);
        save0(1'b1, 1'b1, 12'h000, 1'b1);
        check_frame(0, "old_sum", 64'h1000);
        repeat (5) @(negedge clk);
        chk("second_req_ignored_busy", 64'(fb0), 64'd0);
        chk("second_req_ignored_bytes", 64'(got0.size()), 64'd0);
        save0(1'b1, 1'b1, 12'h000, 1'b1);
        check_frame(0, "new_sum", 64'd4);

        // random operands, B captured on the request cycle itself
        for (int it = 0; it < 6; it++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            if (it == 0) begin ra = 12'hFFF; rb = 12'hFFF; end
            save0(1'b0, 1'b1, ra, 1'b0);
            save0(1'b1, 1'b0, rb, 1'b1);
            check_frame(0, $sformatf("rnd%0d", it), 64'(ra) + 64'(rb));
            chk($sformatf("rnd%0d_sum", it), 64'(sum0), 64'(ra) + 64'(rb));
        end

        // reset while waiting for busy to fall
        save0(1'b1, 1'b1, 12'h000, 1'b1);
        n = 0;
        while (!(got0.size() >= 1 && busy0) && n < 500) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_en", 64'(en0), 64'd0);
        chk("midrst_data", 64'(txd0), 64'd0);
        chk("midrst_sum", 64'(sum0), 64'd0);
        chk("midrst_busy", 64'(fb0), 64'd0);
        chk("midrst_done", 64'(fd0), 64'd0);
        reset = 1'b0;
        got0.delete();
        @(negedge clk);
        save0(1'b1, 1'b1, 12'h000, 1'b1);
        check_frame(0, "after_rst", 64'd0);

        // 4-bit auto-send instance: save_b_n starts the frame
        save1(1'b0, 1'b1, 4'd9);
        save1(1'b1, 1'b0, 4'd8);
        check_frame(1, "auto_9_8", 64'h11);
        chk("auto_sum_11", 64'(sum1), 64'h11);
        save1(1'b0, 1'b1, 4'd15);
        save1(1'b1, 1'b0, 4'd15);
        check_frame(1, "auto_f_f", 64'h1E);
        chk("auto_sum_1e", 64'(sum1), 64'h1E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_frame_tx.md
Name: sum_frame_tx

Overview:
Parametrised successor to the 4-bit latch/adder/UART path. Captures two DATA_W-bit operands from a shared input bus using active-low save strobes and forms the (DATA_W+1)-bit sum. On request, it snapshots the sum and sends a framed byte sequence (sync byte, then sum bytes LSB-first) to the existing uart_tx through an enable/busy handshake. Sits between the operand switches and uart_tx; replaces the free-running uart_tx_en=1 connection.

Parameters:
DATA_W, 4, operand width; legal range 1..32.
SYNC_BYTE, 8'hA5, first byte of every frame.
AUTO_SEND, 0, 1 = a save_b_n capture also acts as send_req.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
save_a_n  in  1  active-low; load operand A from data_input this cycle
save_b_n  in  1  active-low; load operand B from data_input this cycle
data_input  in  DATA_W  shared operand bus
send_req  in  1  one-cycle pulse; start a frame
uart_tx_busy  in  1  busy flag from uart_tx
uart_tx_en  out  1  one-cycle byte-valid strobe to uart_tx
uart_tx_data  out  8  byte to uart_tx; held stable from strobe until busy falls
sum_out  out  DATA_W+1  live registered sum A+B
frame_busy  out  1  high from accepted request until last byte completes
frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset: A=B=0; sum_out=0; uart_tx_en=0; uart_tx_data=0; frame_busy=0; frame_done=0; FSM=IDLE; byte index=0.
- Capture: on a clk edge with save_a_n=0, A<=data_input; likewise for save_b_n and B. Both low in the same cycle: both load the same value. Captures are allowed at any time, including mid-frame.
- sum_out = A+B, zero-extended to DATA_W+1 bits and registered, so it lags an operand capture by 1 cycle (2 cycles from the strobe).
- SUM_W=DATA_W+1; NBYTES=(SUM_W+7)/8. Sum bytes are sent LSB-first. Bits above SUM_W in the top byte are 0.
- FSM states:
  - IDLE: on send_req, or AUTO_SEND and save_b_n low, go to LOAD.
  - LOAD: snapshot sum_out, which must include any operand saved on the request cycle. Load byte 0 = SYNC_BYTE. Go to SEND.
  - SEND: wait until uart_tx_busy=0, then pulse uart_tx_en for 1 cycle. Go to WAIT_ACK.
  - WAIT_ACK: wait for uart_tx_busy=1. Go to WAIT_DONE.
  - WAIT_DONE: wait for uart_tx_busy=0. If more bytes remain, advance the index, load the next byte and go to SEND. Otherwise go to DONE.
  - DONE: pulse frame_done for 1 cycle. Go to IDLE.
- frame_busy=1 in every state except IDLE.
- send_req while frame_busy=1 is ignored, not queued.
- The snapshot is immutable for the whole frame; later captures affect only the next frame.
- Reset asserted mid-frame: immediately return to the reset state. The byte already in uart_tx is not recalled; uart_tx is reset by the same signal.
- Frame length: 1+NBYTES bytes (+1 with the optional feature).

Optional Feature:
SUMFRAME_CHECKSUM_EN
- Defined: append one trailer byte equal to the XOR of all sum bytes (sync byte excluded), sent after the last sum byte with the same handshake. frame_done follows the trailer.
- Undefined: no trailer; the checksum logic is absent.

Decomposition:
- Package sum_frame_pkg holds:
  - state enum (IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, DONE)
  - function nbytes(width)
  - default SYNC_BYTE constant
- Natural sub-module: operand_latch_n. Two DATA_W-bit registers with active-low save strobes plus the registered adder, generalising the existing latch+adder pair. The FSM/serialiser stays in the top.

Test Plan:
- DATA_W=4: save A=9, save B=8, send_req. Required frame: A5, 11; frame_done 1 cycle after the last busy fall; sum_out=5'h11.
- DATA_W=12: A=12'hFFF, B=12'h001, send_req. Required: sum_out=13'h1000; frame A5, 00, 10. With SUMFRAME_CHECKSUM_EN: A5, 00, 10, 10.
- Busy model holds uart_tx_busy=1 for 10 cycles per byte. Check: exactly one uart_tx_en per byte; uart_tx_data stable from strobe until busy falls; no strobe while busy=1.
- Mid-frame: save A=3 after byte 0, then a second send_req during the frame. Required: frame carries the old sum; the second request is ignored; the next request sends the new sum.
- AUTO_SEND=1, DATA_W=4: A=15, then save_b_n low with data 15 and no send_req. Required frame: A5, 1E.
- Assert reset during WAIT_DONE. Next cycle: all outputs at reset values, FSM=IDLE. A new send_req sends A5, 00.
